chunked_serial_adder: RTL and testbench
=======================================

# chunked_serial_adder

Parametrised multi-cycle adder/subtractor: adds (or subtracts) two WIDTH-bit operands CHUNK bits per clock through one shared ripple-carry chunk, with a registered carry between chunks. It is the sequential successor of the team's fixed 4-bit ripple-carry adders. It trades latency for area in wide datapaths and sits behind a valid/ready handshake on both sides, so it drops into streaming arithmetic pipelines.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of CHUNK.
- CHUNK, 4, bits processed per cycle; 1 ≤ CHUNK ≤ WIDTH.
- NCH (localparam), WIDTH/CHUNK, chunk count.
- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand request.
- in_ready  output  1  block can accept; high exactly when state is IDLE.
- a, b  input  WIDTH  operands.
- c_in  input  1  carry-in; ignored when sub=1.
- sub  input  1  0: a+b+c_in; 1: a−b, computed as a+~b+1.
- out_valid  output  1  result available; high exactly when state is DONE.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- c_out  output  1  carry out of MSB; for sub, 1 = no borrow.
- overflow  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - On in_valid && in_ready: latch a into the A shift register.
  - Latch b, or ~b when sub=1, into the B shift register.
  - Set the carry register to c_in, or to 1 when sub=1.
  - Clear chunk counter k; go to RUN.
- RUN, each edge:
  - Add the low CHUNK bits of A and B plus the carry register.
  - Shift A and B right by CHUNK.
  - Shift the CHUNK-bit result into the top of the sum register, which shifts right by CHUNK.
  - Store the chunk carry-out into the carry register; increment k.
- RUN, on the edge with k == NCH−1:
  - Capture c_out, and capture overflow = (carry into chunk MSB) XOR (chunk carry-out).
  - Go to DONE.
- DONE: hold sum/c_out/overflow stable. On out_ready, go to IDLE.
- sum/c_out/overflow keep their last values in IDLE until the next result overwrites them. Only the out_valid cycles are meaningful.
- in_valid is ignored outside IDLE. Operands are sampled only on the accept edge and may change freely afterwards.
- Reset: state IDLE, k=0, all shift and carry registers 0.
  - Output reset values: sum=0, c_out=0, overflow=0, out_valid=0, in_ready=1.
- Reset mid-RUN or mid-DONE aborts the operation. No out_valid is produced for it.
- CHUNK == WIDTH (NCH=1) is legal: RUN lasts exactly one edge.

## Timing
- Accept on edge E0. Chunk i is processed on edge E(i+1).
- out_valid rises after edge E(NCH): latency NCH cycles from acceptance.
- A DONE with out_ready high retires on that edge. in_ready is high the following cycle.
- Minimum issue interval is NCH+2 cycles (no overlap: in_ready low during RUN and DONE).
- in_ready and out_valid are decoded directly from the state register, with no combinational path from in_valid or out_ready.
- Critical path: one CHUNK-bit ripple plus the carry register; independent of WIDTH.

## Structure
- Shared package (adder_pkg): state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2. Other adder variants reuse them.
- Sub-module chunk_adder, parameter N:
  - Generate-loop ripple of full-adder cells.
  - Outputs sum[N-1:0], carry-out, and carry-into-MSB.
  - Purely combinational; instantiated once.
- Top level holds the FSM, counter (width $clog2(NCH) rounded up to ≥1), shift registers, carry register and output registers.

## Test plan
All scenarios use WIDTH=16, CHUNK=4 unless noted.
- a=0x00FF, b=0x0001, c_in=0, sub=0 → sum=0x0100, c_out=0, overflow=0. out_valid rises exactly 4 cycles after the accept edge.
- a=0xFFFF, b=0x0001, c_in=1 → sum=0x0001, c_out=1, overflow=0. a=0x7FFF, b=0x0001 → sum=0x8000, c_out=0, overflow=1.
- sub=1, a=0x0005, b=0x0007, c_in=1 (ignored) → sum=0xFFFE, c_out=0, overflow=0. sub=1, a=0x8000, b=0x0001 → sum=0x7FFF, c_out=1, overflow=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while driving in_valid=1 with new operands.
  - Outputs stay stable and in_ready stays 0 throughout.
  - Raise out_ready: retires in 1 edge, in_ready=1 next cycle, then the new operands are accepted.
- Assert reset for 1 cycle at the second RUN edge → out_valid never rises and outputs read 0. in_ready=1 while reset is asserted. A following op 0x1234+0x4321 → 0x5555.
- CHUNK=16 build: 0xFFFF+0xFFFF, c_in=0 → sum=0xFFFE, c_out=1. out_valid rises 1 cycle after accept. Random compare against a+b+c_in over 1000 ops for CHUNK ∈ {1,4,8,16}.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the adder family: FSM encodings and a counter-width helper.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter width for n chunks, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// Purely combinational N-bit ripple-carry adder built from full-adder cells.
module chunk_adder #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         c_in,
    output logic [N-1:0] sum,
    output logic         c_out,
    output logic         c_msb
);

    logic [N:0] c;

    assign c[0] = c_in;

    for (genvar g = 0; g < N; g++) begin : g_fa
        assign sum[g]   = a[g] ^ b[g] ^ c[g];
        assign c[g + 1] = (a[g] & b[g]) | (a[g] & c[g]) | (b[g] & c[g]);
    end

    // Carry into the top cell is needed for signed overflow detection.
    assign c_out = c[N];
    assign c_msb = c[N-1];

endmodule

// File: rtl/chunked_serial_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor processing CHUNK bits per clock through one shared chunk adder.
module chunked_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow,
    output logic [1:0]       debug_state
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int KW  = cnt_width(NCH);

    // Handshake: a transfer happens on a rising edge where valid && ready; ready and valid
    // are decoded from the state register only, never from the partner's signal.
    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_sr;
    logic [WIDTH-1:0] sum_shift;
    logic             carry;
    logic             c_out_r;
    logic             ovf_r;
    logic [KW-1:0]    k;
    logic             last_chunk;
    logic             accept;
    logic [CHUNK-1:0] ch_sum;
    logic             ch_cout;
    logic             ch_cmsb;

    assign last_chunk = (k == KW'(NCH - 1));
    assign accept     = in_valid && (state == IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)   state_next = RUN;
            RUN:     if (last_chunk) state_next = DONE;
            DONE:    if (out_ready)  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready    = (state == IDLE);
        out_valid   = (state == DONE);
        debug_state = state;
    end

    chunk_adder #(.N(CHUNK)) u_chunk (
        .a     (a_sr[CHUNK-1:0]),
        .b     (b_sr[CHUNK-1:0]),
        .c_in  (carry),
        .sum   (ch_sum),
        .c_out (ch_cout),
        .c_msb (ch_cmsb)
    );

    // With a single chunk the new result replaces the whole register.
    if (NCH == 1) begin : g_one_chunk
        assign sum_shift = ch_sum;
    end else begin : g_multi_chunk
        assign sum_shift = {ch_sum, sum_sr[WIDTH-1:CHUNK]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_sr    <= '0;
            b_sr    <= '0;
            sum_sr  <= '0;
            carry   <= 1'b0;
            c_out_r <= 1'b0;
            ovf_r   <= 1'b0;
            k       <= '0;
        end else if (accept) begin
            a_sr  <= a;
            b_sr  <= sub ? ~b : b;
            carry <= sub | c_in;
            k     <= '0;
        end else if (state == RUN) begin
            a_sr   <= a_sr >> CHUNK;
            b_sr   <= b_sr >> CHUNK;
            sum_sr <= sum_shift;
            carry  <= ch_cout;
            k      <= k + 1'b1;
            if (last_chunk) begin
                c_out_r <= ch_cout;
                ovf_r   <= ch_cmsb ^ ch_cout;
            end
        end
    end

    assign sum      = sum_sr;
    assign c_out    = c_out_r;
    assign overflow = ovf_r;

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Bench for chunked_serial_adder: four instances (CHUNK 4, 1, 8, 16) checked against a scoreboard.
module tb_chunked_serial_adder;

    localparam int W = 16;

    logic clk;
    logic rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic c_in;
    logic sub;
    logic [3:0] iv;
    logic [3:0] orr;
    logic [3:0] ir;
    logic [3:0] ovl;
    logic [3:0] co;
    logic [3:0] of;
    logic [W-1:0] s [4];
    logic [1:0] st [4];

    // Entry layout: {overflow, c_out, sum}
    logic [W+1:0] exp_q [4][$];
    logic [W+1:0] mon_exp;

    int checks;
    int errors;

    chunked_serial_adder #(.WIDTH(W), .CHUNK(4)) dut (
        .clk(clk), .reset(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a(a), .b(b),
        .c_in(c_in), .sub(sub), .out_valid(ovl[0]), .out_ready(orr[0]), .sum(s[0]),
        .c_out(co[0]), .overflow(of[0]), .debug_state(st[0]));

    chunked_serial_adder #(.WIDTH(W), .CHUNK(1)) dut1 (
        .clk(clk), .reset(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a(a), .b(b),
        .c_in(c_in), .sub(sub), .out_valid(ovl[1]), .out_ready(orr[1]), .sum(s[1]),
        .c_out(co[1]), .overflow(of[1]), .debug_state(st[1]));

    chunked_serial_adder #(.WIDTH(W), .CHUNK(8)) dut8 (
        .clk(clk), .reset(rst), .in_valid(iv[2]), .in_ready(ir[2]), .a(a), .b(b),
        .c_in(c_in), .sub(sub), .out_valid(ovl[2]), .out_ready(orr[2]), .sum(s[2]),
        .c_out(co[2]), .overflow(of[2]), .debug_state(st[2]));

    chunked_serial_adder #(.WIDTH(W), .CHUNK(16)) dut16 (
        .clk(clk), .reset(rst), .in_valid(iv[3]), .in_ready(ir[3]), .a(a), .b(b),
        .c_in(c_in), .sub(sub), .out_valid(ovl[3]), .out_ready(orr[3]), .sum(s[3]),
        .c_out(co[3]), .overflow(of[3]), .debug_state(st[3]));

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W+1:0] model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                           input logic tci, input logic tsub);
        logic [W-1:0] bb;
        logic         cc;
        logic [W:0]   f;
        logic         ov;
        bb = tsub ? ~tb : tb;
        cc = tsub ? 1'b1 : tci;
        f  = {1'b0, ta} + {1'b0, bb} + (W+1)'(cc);
        ov = (ta[W-1] == bb[W-1]) && (f[W-1] != ta[W-1]);
        return {ov, f[W], f[W-1:0]};
    endfunction

    // scoreboard monitor
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (ovl[i] && orr[i]) begin
                checks++;
                if (exp_q[i].size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result inst=%0d got sum=%h c_out=%b ovf=%b, none expected",
                             i, s[i], co[i], of[i]);
                end else begin
                    mon_exp = exp_q[i].pop_front();
                    if ({of[i], co[i], s[i]} !== mon_exp) begin
                        errors++;
                        $display("FAIL result inst=%0d got ovf=%b c_out=%b sum=%h expected ovf=%b c_out=%b sum=%h",
                                 i, of[i], co[i], s[i], mon_exp[W+1], mon_exp[W], mon_exp[W-1:0]);
                    end
                end
            end
        end
    end

    // driver tasks
    task automatic wait_ready(input int i);
        int n;
        n = 0;
        while (!ir[i] && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (!ir[i]) begin
            errors++;
            $display("FAIL wait_ready inst=%0d got in_ready=0 expected 1 within 100 cycles", i);
        end
    endtask

    // Issue one op on instance i, push its expectation and check the result latency.
    task automatic run_op(input int i, input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tci, input logic tsub, input logic [W+1:0] e,
                          input int exp_lat);
        int lat;
        wait_ready(i);
        a = ta; b = tb; c_in = tci; sub = tsub;
        exp_q[i].push_back(e);
        iv[i] = 1'b1;
        @(posedge clk);
        #1;
        iv[i] = 1'b0;
        a = $urandom; b = $urandom;
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!ovl[i] && lat < 100);
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL latency inst=%0d got %0d expected %0d", i, lat, exp_lat);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++;
        if (ir !== 4'hF || ovl !== 4'h0 || s[0] !== '0 || co[0] !== 1'b0 || of[0] !== 1'b0
            || st[0] !== 2'd0) begin
            errors++;
            $display("FAIL reset_state got in_ready=%b out_valid=%b sum=%h c_out=%b ovf=%b st=%0d expected F 0 0000 0 0 0",
                     ir, ovl, s[0], co[0], of[0], st[0]);
        end
    endtask

    task automatic test_add();
        run_op(0, 16'h00FF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b0, 16'h0100}, 4);
        run_op(0, 16'hFFFF, 16'h0001, 1'b1, 1'b0, {1'b0, 1'b1, 16'h0001}, 4);
        run_op(0, 16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h8000}, 4);
    endtask

    task automatic test_sub();
        run_op(0, 16'h0005, 16'h0007, 1'b1, 1'b1, {1'b0, 1'b0, 16'hFFFE}, 4);
        run_op(0, 16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 16'h7FFF}, 4);
    endtask

    task automatic test_backpressure();
        int n;
        orr[0] = 1'b0;
        run_op(0, 16'h1111, 16'h2222, 1'b0, 1'b0, {1'b0, 1'b0, 16'h3333}, 4);
        a = 16'hAAAA; b = 16'h0F0F; c_in = 1'b0; sub = 1'b1;
        iv[0] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (ovl[0] !== 1'b1 || ir[0] !== 1'b0 || s[0] !== 16'h3333 || co[0] !== 1'b0
                || of[0] !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold cyc=%0d got out_valid=%b in_ready=%b sum=%h c_out=%b ovf=%b expected 1 0 3333 0 0",
                         c, ovl[0], ir[0], s[0], co[0], of[0]);
            end
            @(posedge clk);
            #1;
        end
        exp_q[0].push_back(model(16'hAAAA, 16'h0F0F, 1'b0, 1'b1));
        orr[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (ir[0] !== 1'b1 || ovl[0] !== 1'b0) begin
            errors++;
            $display("FAIL retire got in_ready=%b out_valid=%b expected 1 0", ir[0], ovl[0]);
        end
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        n = 0;
        while (!ovl[0] && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL backpressure_second_latency got %0d expected 4", n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_abort();
        wait_ready(0);
        a = 16'h0F0F; b = 16'h1234; c_in = 1'b1; sub = 1'b0;
        iv[0] = 1'b1;
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (ir[0] !== 1'b1 || ovl[0] !== 1'b0 || s[0] !== '0 || co[0] !== 1'b0 || of[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort got in_ready=%b out_valid=%b sum=%h c_out=%b ovf=%b expected 1 0 0000 0 0",
                     ir[0], ovl[0], s[0], co[0], of[0]);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++;
            if (ovl[0] !== 1'b0 || s[0] !== '0) begin
                errors++;
                $display("FAIL reset_no_valid cyc=%0d got out_valid=%b sum=%h expected 0 0000", c, ovl[0], s[0]);
            end
        end
        @(posedge clk);
        #1;
        run_op(0, 16'h1234, 16'h4321, 1'b0, 1'b0, {1'b0, 1'b0, 16'h5555}, 4);
    endtask

    task automatic test_chunk16();
        run_op(3, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, {1'b0, 1'b1, 16'hFFFE}, 1);
        run_op(3, 16'h4000, 16'h4000, 1'b0, 1'b0, {1'b1, 1'b0, 16'h8000}, 1);
        run_op(2, 16'h00FF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b0, 16'h0100}, 2);
        run_op(1, 16'hFFFF, 16'h0000, 1'b1, 1'b0, {1'b0, 1'b1, 16'h0000}, 16);
    endtask

    task automatic test_random();
        int n;
        logic [W-1:0] ta, tb;
        logic tci, tsub;
        for (int op = 0; op < 1000; op++) begin
            n = 0;
            while (ir != 4'hF && n < 100) begin
                @(posedge clk);
                #1;
                n++;
            end
            if (ir != 4'hF) begin
                checks++;
                errors++;
                $display("FAIL random_idle op=%0d got in_ready=%b expected 1111", op, ir);
            end
            ta = 16'($urandom);
            tb = 16'($urandom);
            if ($urandom_range(0, 7) == 0) tb = 16'hFFFF;
            tci = 1'($urandom_range(0, 1));
            tsub = 1'($urandom_range(0, 1));
            a = ta; b = tb; c_in = tci; sub = tsub;
            for (int i = 0; i < 4; i++) exp_q[i].push_back(model(ta, tb, tci, tsub));
            iv = 4'hF;
            @(posedge clk);
            #1;
            iv = 4'h0;
            a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom); sub = 1'($urandom);
        end
        n = 0;
        while (ir != 4'hF && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        iv = 4'h0;
        orr = 4'hF;
        a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_add();
        test_sub();
        test_backpressure();
        test_reset_abort();
        test_chunk16();
        test_random();
        repeat (2) @(posedge clk);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (exp_q[i].size() != 0) begin
                errors++;
                $display("FAIL drain inst=%0d got %0d pending expected 0", i, exp_q[i].size());
            end
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
